// File: rtl/ex_alu_pkg.sv
// Shared definitions for the execute-stage ALU: select codes, FSM states and
// shift-type encoding. The select codes are also used by the ALU control unit.
package ex_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_t;

  function automatic logic sel_is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

  function automatic shift_t sel_to_shift(input logic [3:0] sel);
    case (sel)
      ALU_SRL: return SH_RL;
      ALU_SRA: return SH_RA;
      default: return SH_LL;
    endcase
  endfunction

endpackage

// File: rtl/ex_alu_if.sv
// Operand/result handshake bundle between the ALU control side and EX/MEM.
// master = upstream/downstream environment, slave = ex_alu_unit.
interface ex_alu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zf;
  logic            sf;
  logic            cf;
  logic            vf;

  modport master (
    output in_valid, alu_sel, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, zf, sf, cf, vf
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, zf, sf, cf, vf
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-step shifter: load latches data/amount/type, each step
// shifts once and decrements the count; o_last flags the final step.
module alu_serial_shifter
  import ex_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic                    i_clear,
  input  logic [XLEN-1:0]         i_data,
  input  logic [$clog2(XLEN)-1:0] i_amt,
  input  shift_t                  i_type,
  output logic [XLEN-1:0]         o_next,
  output logic                    o_last
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] r_data;
  logic [SW-1:0]   r_cnt;
  shift_t          r_type;

  function automatic logic [XLEN-1:0] step1(input logic [XLEN-1:0] d, input shift_t t);
    case (t)
      SH_LL:   return {d[XLEN-2:0], 1'b0};
      SH_RL:   return {1'b0, d[XLEN-1:1]};
      SH_RA:   return {d[XLEN-1], d[XLEN-1:1]};
      default: return d;
    endcase
  endfunction

  assign o_next = step1(r_data, r_type);
  assign o_last = (r_cnt == SW'(1));

  // Working register and down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_type <= SH_LL;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= i_amt;
      r_type <= i_type;
    end else if (i_step) begin
      r_data <= o_next;
      r_cnt  <= r_cnt - SW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with valid/ready handshake and registered result/flags.
// Define BARREL_SHIFT_EN for single-cycle shifts; default is the serial shifter.
module ex_alu_unit
  import ex_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_alu_if.slave bus
);

  localparam int SW = $clog2(XLEN);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;
  logic            r_zf;
  logic            r_sf;
  logic            r_cf;
  logic            r_vf;

  logic [XLEN-1:0] w_calc;
  logic [XLEN-1:0] w_res_d;
  logic [XLEN-1:0] w_diff;
  logic            w_cf_d;
  logic            w_vf_d;
  logic            w_upd;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_go_serial;

  function automatic logic [XLEN-1:0] alu_calc(input logic [3:0] sel,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SW-1:0] sh;
    sh = b[SW-1:0];
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $signed(a) >>> sh;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
      default:  return '0;
    endcase
  endfunction

  assign w_calc = alu_calc(bus.alu_sel, bus.op_a, bus.op_b);
  assign w_diff = bus.op_a - bus.op_b;

`ifndef BARREL_SHIFT_EN
  logic            w_load;
  logic            w_step;
  logic            w_clear;
  logic [XLEN-1:0] w_sh_next;
  logic            w_sh_last;

  assign w_go_serial = sel_is_shift(bus.alu_sel) && (bus.op_b[SW-1:0] != '0);

  alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_clear (w_clear),
    .i_data  (bus.op_a),
    .i_amt   (bus.op_b[SW-1:0]),
    .i_type  (sel_to_shift(bus.alu_sel)),
    .o_next  (w_sh_next),
    .o_last  (w_sh_last)
  );
`else
  assign w_go_serial = 1'b0;
`endif

  // Ready decode; DONE passes downstream ready straight through for back-to-back issue
  always_comb begin
    w_in_ready = 1'b0;
    if (rst) begin
      w_in_ready = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_in_ready = 1'b1;
        ST_DONE: w_in_ready = bus.out_ready;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = bus.in_valid && !bus.flush && w_in_ready;

  // Next-state and datapath control; flush overrides any accept or shift step
  always_comb begin
    w_next  = r_state;
    w_upd   = 1'b0;
    w_res_d = r_result;
    w_cf_d  = 1'b0;
    w_vf_d  = 1'b0;
`ifndef BARREL_SHIFT_EN
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_clear = 1'b0;
`endif
    if (bus.flush) begin
      w_next = ST_IDLE;
`ifndef BARREL_SHIFT_EN
      w_clear = 1'b1;
`endif
    end else if (w_accept) begin
      if (w_go_serial) begin
`ifndef BARREL_SHIFT_EN
        w_load = 1'b1;
`endif
        w_next = ST_SHIFT;
      end else begin
        w_upd   = 1'b1;
        w_res_d = w_calc;
        w_next  = ST_DONE;
        if (bus.alu_sel == ALU_SUB) begin
          w_cf_d = (bus.op_a >= bus.op_b);
          w_vf_d = (bus.op_a[XLEN-1] != bus.op_b[XLEN-1]) &&
                   (w_diff[XLEN-1] != bus.op_a[XLEN-1]);
        end else begin
          w_cf_d = 1'b0;
          w_vf_d = 1'b0;
        end
      end
    end else begin
      case (r_state)
        ST_DONE: begin
          if (bus.out_ready) w_next = ST_IDLE;
          else               w_next = ST_DONE;
        end
`ifndef BARREL_SHIFT_EN
        ST_SHIFT: begin
          w_step = 1'b1;
          if (w_sh_last) begin
            w_upd   = 1'b1;
            w_res_d = w_sh_next;
            w_next  = ST_DONE;
          end else begin
            w_next = ST_SHIFT;
          end
        end
`endif
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State, valid and result/flag registers; result is held while not updated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_cf        <= 1'b0;
      r_vf        <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == ST_DONE);
      if (w_upd) begin
        r_result <= w_res_d;
        r_zf     <= (w_res_d == '0);
        r_sf     <= w_res_d[XLEN-1];
        r_cf     <= w_cf_d;
        r_vf     <= w_vf_d;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zf        = r_zf;
  assign bus.sf        = r_sf;
  assign bus.cf        = r_cf;
  assign bus.vf        = r_vf;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed vector table, hand-written
// handshake/flush/reset sequences and randomized ops against a reference model.
module tb_ex_alu_unit;
  import ex_alu_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  ex_alu_if #(.XLEN(32)) bus ();

  ex_alu_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {zf, sf, cf, vf}
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
  } model_t;

  vec_t tbl[12];
  logic [3:0] codes[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model straight from the operation definitions
  function automatic model_t model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    model_t m;
    longint sa, sb, d;
    int     sh;
    logic   cf, vf;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b[4:0]);
    cf = 1'b0;
    vf = 1'b0;
    case (sel)
      ALU_ADD:  m.res = a + b;
      ALU_SUB: begin
        m.res = a - b;
        d  = sa - sb;
        cf = (a >= b);
        vf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
      end
      ALU_OR:   m.res = a | b;
      ALU_AND:  m.res = a & b;
      ALU_XOR:  m.res = a ^ b;
      ALU_SLL:  m.res = a << sh;
      ALU_SRL:  m.res = a >> sh;
      ALU_SRA:  m.res = 32'(sa >>> sh);
      ALU_SLT:  m.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: m.res = (a < b) ? 32'd1 : 32'd0;
      default:  m.res = 32'd0;
    endcase
    m.fl = {(m.res == 32'd0), m.res[31], cf, vf};
    return m;
  endfunction

  function automatic int exp_latency(input logic [3:0] sel, input logic [31:0] b);
`ifdef BARREL_SHIFT_EN
    return 1;
`else
    if (sel_is_shift(sel) && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    else return 1;
`endif
  endfunction

  // Issue one op with out_ready high, then check latency, result and flags
  task automatic do_op(input string nm, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int lat;
    bus.alu_sel   = sel;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a     = $urandom;
    bus.op_b     = $urandom;
    bus.alu_sel  = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_latency(sel, b)));
    check({nm, " result"}, 64'(bus.result), 64'(exp_res));
    check({nm, " flags"}, 64'({bus.zf, bus.sf, bus.cf, bus.vf}), 64'(exp_fl));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_t m;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    int          bad;

    n_pass  = 0;
    n_total = 0;
    tbl[0]  = '{"add_zero",  ALU_ADD,  32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 4'b1000};
    tbl[1]  = '{"sub_ovf",   ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011};
    tbl[2]  = '{"sub_borrow",ALU_SUB,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b0100};
    tbl[3]  = '{"sra_31",    ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 4'b0100};
    tbl[4]  = '{"sra_0",     ALU_SRA,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0100};
    tbl[5]  = '{"sltu",      ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000};
    tbl[6]  = '{"slt_neg",   ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
    tbl[7]  = '{"and",       ALU_AND,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000};
    tbl[8]  = '{"or",        ALU_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000};
    tbl[9]  = '{"xor",       ALU_XOR,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 4'b0100};
    tbl[10] = '{"srl_31",    ALU_SRL,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000};
    tbl[11] = '{"bad_code",  4'b0011,  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000};
    codes = '{ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SLL,
              ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, 4'b0110};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_sel   = 4'd0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst result", 64'(bus.result), 64'd0);
    check("rst flags", 64'({bus.zf, bus.sf, bus.cf, bus.vf}), 64'b1000);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].name, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].fl);

    // Back-pressure: SLTU result held for 3 cycles, then back-to-back AND
    @(negedge clk);
    bus.alu_sel   = ALU_SLTU;
    bus.op_a      = 32'h1;
    bus.op_b      = 32'hFFFF_FFFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (!(bus.out_valid === 1'b1 && bus.result === 32'd1 && bus.in_ready === 1'b0)) bad++;
      @(negedge clk);
    end
    check("bp hold", 64'(bad), 64'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_sel   = ALU_AND;
    bus.op_a      = 32'h0000_F0F0;
    bus.op_b      = 32'h0000_0FF0;
    #1;
    check("b2b in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b out_valid", 64'(bus.out_valid), 64'd1);
    check("b2b result", 64'(bus.result), 64'h0000_00F0);
    @(negedge clk);
    check("b2b drained", 64'(bus.out_valid), 64'd0);

`ifndef BARREL_SHIFT_EN
    // Flush mid-shift: SLL 1 by 20, flush in the fifth cycle
    bus.alu_sel  = ALU_SLL;
    bus.op_a     = 32'h1;
    bus.op_b     = 32'd20;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i < 5; i++) begin
      if (!(bus.out_valid === 1'b0 && bus.in_ready === 1'b0)) bad++;
      @(negedge clk);
    end
    check("shift busy", 64'(bad), 64'd0);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush in_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    check("flush no valid", 64'(bad), 64'd0);
`endif
    do_op("add_after", ALU_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);

    // Async reset between edges while a long shift is in flight
    @(negedge clk);
    bus.alu_sel  = ALU_SRL;
    bus.op_a     = 32'hFFFF_FFFF;
    bus.op_b     = 32'd31;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst out_valid", 64'(bus.out_valid), 64'd0);
    check("arst result", 64'(bus.result), 64'd0);
    check("arst zf", 64'(bus.zf), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("arst idle", 64'(bus.out_valid), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      sel = codes[$urandom_range(0, 10)];
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 3) == 0) a = a | 32'h8000_0000;
      m = model(sel, a, b);
      do_op($sformatf("rnd%0d", i), sel, a, b, m.res, m.fl);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage ALU datapath that sits directly downstream of the ALU control unit.
- Consumes the 4-bit ALU select code plus the two operands and produces a registered result and branch flags for the EX/MEM register.
- Non-shift operations complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter, and the stage back-pressures the pipeline through a valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width; must be a power of 2, at least 8. Shift amount width SW = log2(XLEN), derived internally.

Ports:
- clk  input  1  stage clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept an operation this cycle
- alu_sel  input  4  select code from ALU control unit
- op_a  input  XLEN  operand A (rs1 or PC)
- op_b  input  XLEN  operand B (rs2 or immediate); op_b[SW-1:0] is the shift amount
- flush  input  1  kill the in-flight operation (branch mispredict or trap)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- result  output  XLEN  ALU result
- zf  output  1  result == 0
- sf  output  1  result[XLEN-1]
- cf  output  1  SUB only: 1 when op_a >= op_b unsigned (no borrow); else 0
- vf  output  1  SUB only: signed overflow of op_a - op_b; else 0

Behaviour:
- Reset is asynchronous, active-high. While rst is asserted: state = IDLE, out_valid = 0, result = 0, zf = 1, sf = cf = vf = 0, shift counter = 0. in_ready = 1 once rst deasserts.
- Select codes:
  - 0000 ADD; 0001 SUB
  - 0100 OR; 0101 AND; 0111 XOR
  - 1000 SLL; 1001 SRL; 1010 SRA
  - 1101 SLT (signed; result is 1 or 0); 1111 SLTU (unsigned)
  - Any other code: result = 0, no error.
- Arithmetic wraps modulo 2^XLEN.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1, out_valid = 0. On in_valid && !flush:
  - If the operation is not a shift, or the shift amount is 0: compute result and flags, go to DONE.
  - Otherwise: latch op_a, the shift direction/type and count = shamt, go to SHIFT.
- SHIFT: in_ready = 0, out_valid = 0.
  - Each cycle, shift the working register 1 bit; SRA replicates the sign bit.
  - Decrement count; when count reaches 1 this cycle, go to DONE with flags computed from the final value.
- DONE: out_valid = 1; result and flags are held stable until out_ready.
  - in_ready = out_ready, so a new operation is accepted in the same cycle the result is consumed.
  - On out_ready && in_valid: the new operation follows the IDLE rules (back-to-back, no bubble).
  - On out_ready && !in_valid: go to IDLE.
- Latency from the accept edge:
  - Non-shift, or shamt = 0: out_valid high on the next cycle.
  - Shift by k: out_valid high after k+1 edges. Maximum is XLEN, for shamt = XLEN-1.
- Flush has priority over everything except rst:
  - From any state, go to IDLE next cycle; out_valid drops next cycle.
  - No accept takes place in a flush cycle, even if in_valid = 1.
  - result and flags keep their last values (don't-care while out_valid = 0).
- Inputs are sampled only at accept. op_a, op_b and alu_sel may change freely during SHIFT and DONE.
- rst asserted mid-shift aborts the operation immediately; all outputs take their reset values.

Optional Feature:
- BARREL_SHIFT_EN:
  - Defined: shifts use a single-cycle barrel shifter; every operation goes IDLE/DONE to DONE in 1 cycle, the SHIFT state and counter are not generated, and in_ready is never 0 except in DONE with !out_ready.
  - Undefined (default): iterative shifter as described above.
  - Results and flags are bit-identical in both builds; only latency differs.

Decomposition:
- Package ex_alu_pkg holds:
  - localparams for the ten ALU select codes, shared with the ALU control unit;
  - the FSM state typedef (IDLE/SHIFT/DONE, 2 bits);
  - the shift-type encoding (LL/RL/RA).
- One natural sub-module, alu_serial_shifter: load/step interface, holds the working register and down-counter, asserts a last-step flag. It is replaced by combinational logic under BARREL_SHIFT_EN.

Test Plan:
- Reset and ADD: rst pulse, then ADD 0x00000005 + 0xFFFFFFFB → out_valid on the next cycle, result 0, zf = 1.
- SUB flags:
  - 0x80000000 - 0x00000001 → result 0x7FFFFFFF, vf = 1, cf = 1.
  - 0x1 - 0x2 → result 0xFFFFFFFF, cf = 0, sf = 1.
- SRA serial: op_a 0x80000000, shamt 31 → in_ready low 31 cycles, out_valid at edge 32, result 0xFFFFFFFF. Repeat with shamt 0 → 1-cycle latency, result = op_a.
- Back-pressure and back-to-back: out_ready low for 3 cycles with SLTU 0x1 < 0xFFFFFFFF → result holds 1; then out_ready = 1 with a new AND 0xF0F0 & 0x0FF0 → next cycle result 0x00F0, no bubble.
- Flush mid-shift: SLL 0x1 by 20, flush at cycle 5 → IDLE next cycle, out_valid never rises; the next ADD 2 + 3 gives 5 with 1-cycle latency.
- Async reset mid-shift: rst asserted between clock edges during SHIFT → out_valid = 0 and result = 0 immediately; in_ready = 1 after deassert.
